// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: OV7670-style DVP transmitter, serializes RGB565 pixels onto vsync/href/8-bit byte bus, high byte first
// Ports: clk/rst_n clock and async active-low reset; start begins one frame (ignored unless idle);
// pix_data/pix_valid/pix_ready pixel stream (ready on every other LINE cycle, no stall);
// dvp_vsync/dvp_href/dvp_data camera bus; busy frame in progress; frame_done one-cycle end pulse;
// underflow sticky missing-pixel flag, cleared by an accepted start.
module dvp_frame_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 288,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow
);
    localparam int LINE_CYC = 2 * H_ACTIVE + H_BLANK;
    localparam int TOT      = VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int CW       = LINE_CYC > 1 ? $clog2(LINE_CYC) : 1;
    localparam int LW       = TOT > 1 ? $clog2(TOT) : 1;
    typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK, VFP} state_t;
    // Zero-length phases are skipped by resolving their successors at elaboration
    localparam state_t S_AFTER_VS = (VBP_LINES > 0) ? VBP : LINE;
    localparam state_t S_ENTRY    = (VSYNC_LINES > 0) ? VSYNC : S_AFTER_VS;
    localparam state_t S_END      = (VFP_LINES > 0) ? VFP : IDLE;
    localparam logic [CW-1:0] COL_END = CW'(LINE_CYC - 1);
    localparam logic [CW-1:0] COL_ACT = CW'(2 * H_ACTIVE - 1);
    localparam logic [LW-1:0] L_VS  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_VBP = LW'(VBP_LINES - 1);
    localparam logic [LW-1:0] L_ACT = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] L_VFP = LW'(VFP_LINES - 1);
    state_t          state, nxt;
    logic [CW-1:0]   col;
    logic [LW-1:0]   lin;
    logic            phase;
    logic [7:0]      lo;
    logic            eol, last_act, grp_chg, fin, accept;
    assign eol       = col == COL_END;
    assign last_act  = lin == L_ACT;
    assign pix_ready = (state == LINE) && !phase;
    assign fin       = (state != IDLE) && (nxt == IDLE);
    assign accept    = (state == IDLE) && (nxt != IDLE);
    // LINE and HBLANK share the active-line counter; any other transition restarts it
    assign grp_chg   = (state != nxt) &&
                       !((state == LINE || state == HBLANK) && (nxt == LINE || nxt == HBLANK));
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (start && !frame_done) ? S_ENTRY : IDLE;
            VSYNC:   nxt = (eol && lin == L_VS) ? S_AFTER_VS : VSYNC;
            VBP:     nxt = (eol && lin == L_VBP) ? LINE : VBP;
            LINE:    nxt = (col != COL_ACT) ? LINE : (H_BLANK > 0) ? HBLANK : last_act ? S_END : LINE;
            HBLANK:  nxt = !eol ? HBLANK : last_act ? S_END : LINE;
            VFP:     nxt = (eol && lin == L_VFP) ? IDLE : VFP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            lin        <= '0;
            phase      <= 1'b0;
            lo         <= 8'h00;
            dvp_data   <= 8'h00;
            dvp_href   <= 1'b0;
            dvp_vsync  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= nxt;
            col        <= (state == IDLE || nxt == IDLE || eol) ? '0 : col + 1'b1;
            lin        <= grp_chg ? '0 : eol ? lin + 1'b1 : lin;
            phase      <= (state == LINE) && !phase;
            lo         <= pix_ready ? (pix_valid ? pix_data[7:0] : 8'h00) : lo;
            dvp_data   <= pix_ready ? (pix_valid ? pix_data[15:8] : 8'h00) : (state == LINE) ? lo : 8'h00;
            dvp_href   <= state == LINE;
            dvp_vsync  <= state == VSYNC;
            busy       <= (state != IDLE) && !fin;
            frame_done <= fin;
            underflow  <= accept ? 1'b0 : underflow | (pix_ready && !pix_valid);
        end
    end
endmodule

// File: tb/tb_dvp_frame_tx.sv
// tb_dvp_frame_tx: directed self-checking bench for dvp_frame_tx with a 4x2 active frame (LINE_CYC 11, 55 cycles)
module tb_dvp_frame_tx;
    logic        clk = 1'b0;
    logic        rst_n, start, pix_valid, pix_ready, clr;
    logic [15:0] pix_data;
    logic        dvp_vsync, dvp_href, busy, frame_done, underflow;
    logic [7:0]  dvp_data;
    logic [3:0]  pidx;
    int          drop, consec, tests = 0, fails = 0;
    logic        prev_rdy;
    logic [15:0] pix_tab [8] = '{16'h1234, 16'hABCD, 16'h5678, 16'h9EF0,
                                 16'h1357, 16'h2468, 16'hCAFE, 16'hBEEF};
    logic        cap_vs [0:62], cap_hr [0:62], cap_fd [0:62], cap_bz [0:62], cap_uf [0:62];
    logic [7:0]  cap_d  [0:62];

    dvp_frame_tx #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .busy(busy), .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    assign pix_data  = pix_tab[pidx[2:0]];
    assign pix_valid = int'(pidx) != drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pidx     <= '0;
            prev_rdy <= 1'b0;
            consec   <= 0;
        end else begin
            pidx     <= clr ? 4'd0 : pix_ready ? pidx + 4'd1 : pidx;
            prev_rdy <= pix_ready;
            if (pix_ready && prev_rdy) consec <= consec + 1;
        end
    end

    function automatic bit exp_href(int k);
        return (k >= 23 && k <= 30) || (k >= 34 && k <= 41);
    endfunction

    function automatic logic [7:0] exp_byte(int k, int dp);
        int off, p;
        logic [15:0] w;
        if (!exp_href(k)) return 8'h00;
        off = (k >= 34) ? k - 34 + 8 : k - 23;
        p   = off / 2;
        w   = (p == dp) ? 16'h0000 : pix_tab[p];
        return off[0] ? w[7:0] : w[15:8];
    endfunction

    // Pulses start (edge N) and records cycles 1..62 sampled 1ns after each edge; ex1/ex2 re-pulse start in those cycles
    task automatic capture(input int ex1, input int ex2);
        start = 1'b1;
        clr   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clr = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            @(posedge clk);
            #1;
            cap_vs[k] = dvp_vsync;
            cap_hr[k] = dvp_href;
            cap_d[k]  = dvp_data;
            cap_fd[k] = frame_done;
            cap_bz[k] = busy;
            cap_uf[k] = underflow;
            start = (k == ex1 || k == ex2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic any_out, any_rdy;
        #3;
        tests++;
        if ({dvp_vsync, dvp_href, dvp_data, busy, frame_done, underflow, pix_ready} !== 14'h0) begin
            fails++;
            $display("FAIL reset_values: got %b expected all 0",
                     {dvp_vsync, dvp_href, dvp_data, busy, frame_done, underflow, pix_ready});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        any_out = 1'b0;
        any_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            any_out |= dvp_vsync | dvp_href | (|dvp_data) | busy | frame_done | underflow;
            any_rdy |= pix_ready;
        end
        tests++;
        if (any_out !== 1'b0) begin fails++; $display("FAIL idle_outputs: got %b expected 0", any_out); end
        tests++;
        if (any_rdy !== 1'b0) begin fails++; $display("FAIL idle_pix_ready: got %b expected 0", any_rdy); end
    endtask

    task automatic test_frame;
        capture(0, 0);
        for (int k = 1; k <= 62; k++) begin
            tests++;
            if (cap_vs[k] !== (k >= 1 && k <= 11)) begin
                fails++; $display("FAIL frame_vsync c%0d: got %b expected %b", k, cap_vs[k], k <= 11);
            end
            tests++;
            if (cap_hr[k] !== exp_href(k)) begin
                fails++; $display("FAIL frame_href c%0d: got %b expected %b", k, cap_hr[k], exp_href(k));
            end
            tests++;
            if (cap_d[k] !== exp_byte(k, 99)) begin
                fails++; $display("FAIL frame_data c%0d: got %h expected %h", k, cap_d[k], exp_byte(k, 99));
            end
            tests++;
            if (cap_fd[k] !== (k == 55)) begin
                fails++; $display("FAIL frame_done c%0d: got %b expected %b", k, cap_fd[k], k == 55);
            end
            tests++;
            if (cap_bz[k] !== (k <= 54)) begin
                fails++; $display("FAIL frame_busy c%0d: got %b expected %b", k, cap_bz[k], k <= 54);
            end
        end
        tests++;
        if (pidx !== 4'd8) begin fails++; $display("FAIL frame_transfers: got %0d expected 8", pidx); end
        tests++;
        if (consec !== 0) begin fails++; $display("FAIL ready_consecutive: got %0d expected 0", consec); end
        tests++;
        if (cap_uf[62] !== 1'b0) begin fails++; $display("FAIL frame_underflow: got %b expected 0", cap_uf[62]); end
    endtask

    task automatic test_underflow;
        drop = 2;
        capture(0, 0);
        drop = 99;
        for (int k = 23; k <= 41; k++) begin
            tests++;
            if (cap_d[k] !== exp_byte(k, 2)) begin
                fails++; $display("FAIL uf_data c%0d: got %h expected %h", k, cap_d[k], exp_byte(k, 2));
            end
        end
        tests++;
        if (cap_d[27] !== 8'h00 || cap_d[28] !== 8'h00) begin
            fails++; $display("FAIL uf_slot: got %h%h expected 0000", cap_d[27], cap_d[28]);
        end
        tests++;
        if (cap_uf[26] !== 1'b0) begin fails++; $display("FAIL uf_early: got %b expected 0", cap_uf[26]); end
        tests++;
        if (cap_uf[27] !== 1'b1) begin fails++; $display("FAIL uf_set: got %b expected 1", cap_uf[27]); end
        tests++;
        if (cap_uf[62] !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", cap_uf[62]); end
        capture(0, 0);
        tests++;
        if (cap_uf[1] !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b expected 0", cap_uf[1]); end
        tests++;
        if (cap_d[27] !== 8'h56) begin fails++; $display("FAIL uf_next_data: got %h expected 56", cap_d[27]); end
    endtask

    task automatic test_start_ignored;
        int nfd;
        capture(10, 55);
        nfd = 0;
        for (int k = 1; k <= 62; k++) nfd += int'(cap_fd[k]);
        tests++;
        if (nfd !== 1) begin fails++; $display("FAIL ign_done_count: got %0d expected 1", nfd); end
        tests++;
        if (cap_fd[55] !== 1'b1) begin fails++; $display("FAIL ign_done_cycle: got %b expected 1", cap_fd[55]); end
        for (int k = 12; k <= 62; k++) begin
            tests++;
            if (cap_vs[k] !== 1'b0) begin fails++; $display("FAIL ign_vsync c%0d: got %b expected 0", k, cap_vs[k]); end
        end
        for (int k = 55; k <= 62; k++) begin
            tests++;
            if (cap_bz[k] !== 1'b0) begin fails++; $display("FAIL ign_busy c%0d: got %b expected 0", k, cap_bz[k]); end
        end
        tests++;
        if (cap_hr[34] !== 1'b1 || cap_d[34] !== 8'h13) begin
            fails++; $display("FAIL ign_timing: got href %b data %h expected 1 13", cap_hr[34], cap_d[34]);
        end
    endtask

    task automatic test_async_reset;
        start = 1'b1;
        clr   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clr = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        tests++;
        if (pix_ready !== 1'b1 || dvp_href !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL rst_pre: got rdy %b href %b busy %b expected 1 1 1", pix_ready, dvp_href, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({dvp_vsync, dvp_href, dvp_data, busy, frame_done, underflow, pix_ready} !== 14'h0) begin
            fails++;
            $display("FAIL rst_async: got %b expected all 0",
                     {dvp_vsync, dvp_href, dvp_data, busy, frame_done, underflow, pix_ready});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || dvp_vsync !== 1'b0) begin
            fails++; $display("FAIL rst_wait: got busy %b vsync %b expected 0 0", busy, dvp_vsync);
        end
        capture(0, 0);
        for (int k = 1; k <= 62; k++) begin
            tests++;
            if (cap_d[k] !== exp_byte(k, 99) || cap_hr[k] !== exp_href(k)) begin
                fails++; $display("FAIL rst_frame c%0d: got %b/%h expected %b/%h", k, cap_hr[k], cap_d[k],
                                  exp_href(k), exp_byte(k, 99));
            end
        end
        tests++;
        if (cap_fd[55] !== 1'b1) begin fails++; $display("FAIL rst_done: got %b expected 1", cap_fd[55]); end
        tests++;
        if (pidx !== 4'd8) begin fails++; $display("FAIL rst_transfers: got %0d expected 8", pidx); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        drop  = 99;
        test_reset;
        test_frame;
        test_underflow;
        test_start_ignored;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dvp_frame_tx.md
# dvp_frame_tx

Synthesizable OV7670-style DVP (digital video port) transmitter. It serializes a pixel stream of RGB565 words into the camera byte bus: `vsync`, `href` and 8-bit data, with one byte per `clk` cycle and the high byte first. It is the sending end of the interface consumed by `camera_read`. It replays stored or generated frames into the capture path, either for loopback self-test on the board or as the camera model in simulation benches.

## Interface
Parameters:
- `H_ACTIVE`, 640, pixels per active line (each pixel is 2 bytes).
- `V_ACTIVE`, 480, active lines per frame.
- `H_BLANK`, 288, `href`-low cycles after each active line's bytes.
- `VSYNC_LINES`, 3, line periods with `vsync` high at frame start.
- `VBP_LINES`, 17, line periods after `vsync` before the first active line.
- `VFP_LINES`, 10, line periods after the last active line.

Ports (clock and reset first):
- `clk`, input, 1. Single clock. One DVP byte per cycle; the consumer samples on the same edge domain.
- `rst_n`, input, 1. Asynchronous, active-low reset.
- `start`, input, 1. One-cycle pulse that begins one frame. Ignored while `busy`.
- `pix_data`, input, 16. RGB565 pixel: `[15:11]` R, `[10:5]` G, `[4:0]` B.
- `pix_valid`, input, 1. `pix_data` is valid.
- `pix_ready`, output, 1. The block takes a pixel this cycle.
- `dvp_vsync`, output, 1. Frame sync, active high.
- `dvp_href`, output, 1. Line-valid, high for exactly 2·`H_ACTIVE` cycles per active line.
- `dvp_data`, output, 8. Byte bus.
- `busy`, output, 1. A frame is in progress.
- `frame_done`, output, 1. One-cycle pulse when a frame completes.
- `underflow`, output, 1. Sticky: a pixel slot found `pix_valid` low. Cleared by `start` or reset.

## Operation
- Line period: `LINE_CYC` = 2·`H_ACTIVE` + `H_BLANK` cycles. Every vsync, porch and active line lasts exactly `LINE_CYC`.
- Internal state is tracked with a column counter (`$clog2(LINE_CYC)` bits), a line counter (`$clog2` of the total line count) and a byte-phase bit.
- States:
  - IDLE: `start` → VSYNC.
  - VSYNC: `VSYNC_LINES` line periods → VBP.
  - VBP: `VBP_LINES` line periods → LINE.
  - LINE: 2·`H_ACTIVE` cycles → HBLANK.
  - HBLANK: `H_BLANK` cycles → LINE if active lines remain, else → VFP.
  - VFP: `VFP_LINES` line periods → IDLE, pulsing `frame_done`.
- If any of `VSYNC_LINES`, `VBP_LINES`, `VFP_LINES` or `H_BLANK` is 0, its state is skipped.
- `pix_ready` = (state == LINE) && (phase == 0). It is combinational from registered state and independent of `pix_valid`.
- On a phase-0 LINE cycle:
  - Register `dvp_data` ← `pix_data[15:8]`.
  - Hold `pix_data[7:0]` for the phase-1 cycle.
  - If `pix_valid` = 0, substitute 0x0000 and set `underflow`. There is no stall; frame timing is fixed.
- On a phase-1 cycle, `dvp_data` ← held low byte.
- `dvp_href` is registered: high on the cycle after each LINE-state cycle.
- `dvp_vsync` is registered: high on the cycle after each VSYNC-state cycle.
- `dvp_data` is 0x00 whenever `dvp_href` is low.
- `busy` is high from the cycle after `start` is accepted through the last VFP cycle.
- `start` is sampled only in IDLE. A `start` on the same cycle as `frame_done` is ignored; the next frame needs a later pulse.

## Timing
- Reset values: `dvp_vsync`, `dvp_href`, `dvp_data`, `busy`, `frame_done`, `underflow`, `pix_ready` all 0. State = IDLE, counters = 0.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). After reset, the block waits for a new `start`.
- `start` at edge N: `busy` = 1 and `dvp_vsync` = 1 from edge N+1.
- Pixel latency: a pixel taken at edge M (pix_ready high) shows its high byte on `dvp_data` at edge M+1 and its low byte at M+2.
- Frame length from accepting `start` to `frame_done`: (`VSYNC_LINES` + `VBP_LINES` + `V_ACTIVE` + `VFP_LINES`)·`LINE_CYC` cycles.
- `frame_done` is coincident with the first cycle of `busy` = 0.
- Per frame, `pix_ready` asserts exactly `H_ACTIVE`·`V_ACTIVE` times, never on consecutive cycles.

## Test plan
Parameters for all scenarios unless stated: `H_ACTIVE`=4, `V_ACTIVE`=2, `H_BLANK`=3, `VSYNC_LINES`=1, `VBP_LINES`=1, `VFP_LINES`=1. This gives `LINE_CYC`=11 and a 55-cycle frame.

1. Reset, then idle 20 cycles → all outputs 0, `pix_ready` never asserted.
2. `start`, pixels 0x1234, 0xABCD, … always valid → `vsync` high cycles 1–11; `href` high cycles 23–30 and 34–41; data 12,34,AB,CD,…; `frame_done` at cycle 55; exactly 8 transfers.
3. Drive `pix_valid`=0 for the 3rd pixel → bytes 00,00 in its slot; `underflow`=1 sticky; next `start` clears it.
4. `start` pulsed again at cycle 10 and at the `frame_done` cycle → both ignored, single 55-cycle frame.
5. Assert `rst_n`=0 during the second active line → outputs 0 without waiting for a clock; a fresh `start` after release yields a complete, correct frame.
6. Default parameters, loopback into `camera_read` → 307200 `pixel_valid` pulses, reassembled pixels equal sent pixels, one `frame_done`.
